// File: rtl/cep_tx_arb_pkg.sv
// Shared widths, field layout and types for the CEP transmit path.
// Packet = eight 64-bit subwords: 0 header, responses carry data in 1..7,
// requests carry addr/chipid in 1, zero in 2 and data in 3..7.
package cep_tx_arb_pkg;

  localparam int unsigned CEP_WORD_WIDTH         = 64;
  localparam int unsigned CEP_DATA_WIDTH         = 8 * CEP_WORD_WIDTH;

  localparam int unsigned CEP_LAST_SUBLINE_WIDTH = 1;
  localparam int unsigned CEP_SUBLINE_ID_WIDTH   = 2;
  localparam int unsigned CEP_MESI_WIDTH         = 2;
  localparam int unsigned CEP_MSHRID_WIDTH       = 8;
  localparam int unsigned CEP_MSG_TYPE_WIDTH     = 8;
  localparam int unsigned CEP_LENGTH_WIDTH       = 8;
  localparam int unsigned CEP_DATA_SIZE_WIDTH    = 3;
  localparam int unsigned CEP_CACHE_TYPE_WIDTH   = 1;
  localparam int unsigned CEP_ADDR_WIDTH         = 40;
  localparam int unsigned CEP_SRC_CHIPID_WIDTH   = 14;

  localparam int unsigned CEP_REQ_DATA_WORDS     = 5;
  localparam int unsigned CEP_RESP_DATA_WORDS    = 7;
  localparam int unsigned CEP_REQ_DATA_WIDTH     = CEP_REQ_DATA_WORDS * CEP_WORD_WIDTH;
  localparam int unsigned CEP_RESP_DATA_WIDTH    = CEP_RESP_DATA_WORDS * CEP_WORD_WIDTH;
  localparam int unsigned CEP_STARVE_CNT_WIDTH   = 4;

  // Header subword bit positions
  localparam int unsigned CEP_MSG_TYPE_LO        = 0;
  localparam int unsigned CEP_LENGTH_LO          = 8;
  localparam int unsigned CEP_MSHRID_LO          = 16;
  localparam int unsigned CEP_MESI_LO            = 24;
  localparam int unsigned CEP_SUBLINE_ID_LO      = 26;
  localparam int unsigned CEP_LAST_SUBLINE_LO    = 28;
  localparam int unsigned CEP_IS_REQ_BIT         = 29;
  localparam int unsigned CEP_DATA_SIZE_LO       = 30;
  localparam int unsigned CEP_CACHE_TYPE_LO      = 33;
  localparam int unsigned CEP_ADDR_LO            = 64;
  localparam int unsigned CEP_SRC_CHIPID_LO      = 104;

  localparam int unsigned CEP_RESP_DATA_SUBWORD  = 1;
  localparam int unsigned CEP_REQ_DATA_SUBWORD   = 3;

  typedef logic [CEP_STARVE_CNT_WIDTH-1:0] starve_cnt_t;

  typedef struct packed {
    logic [CEP_LAST_SUBLINE_WIDTH-1:0] last_subline;
    logic [CEP_SUBLINE_ID_WIDTH-1:0]   subline_id;
    logic [CEP_MESI_WIDTH-1:0]         mesi;
    logic [CEP_MSHRID_WIDTH-1:0]       mshrid;
    logic [CEP_MSG_TYPE_WIDTH-1:0]     msg_type;
    logic [CEP_LENGTH_WIDTH-1:0]       length;
  } cep_hdr_t;

  typedef struct packed {
    logic [CEP_DATA_SIZE_WIDTH-1:0]  data_size;
    logic [CEP_CACHE_TYPE_WIDTH-1:0] cache_type;
    logic [CEP_ADDR_WIDTH-1:0]       addr;
    logic [CEP_SRC_CHIPID_WIDTH-1:0] src_chipid;
  } cep_req_ext_t;

  // Requests carry fewer payload words; the missing upper words go out as zero.
  function automatic logic [CEP_RESP_DATA_WIDTH-1:0] cep_pad_req_data(
    input logic [CEP_REQ_DATA_WIDTH-1:0] data
  );
    logic [CEP_RESP_DATA_WIDTH-1:0] padded;
    padded = '0;
    padded[CEP_REQ_DATA_WIDTH-1:0] = data;
    return padded;
  endfunction

endpackage

// File: rtl/cep_tx_arb_encoder.sv
// Packs header, request extension and payload words into one CEP packet.
// Purely combinational; the caller zeroes the request extension for responses.
module cep_tx_arb_encoder
  import cep_tx_arb_pkg::*;
(
  input  logic                           is_request_i,
  input  cep_hdr_t                       hdr_i,
  input  cep_req_ext_t                   ext_i,
  input  logic [CEP_RESP_DATA_WIDTH-1:0] data_i,
  output logic [CEP_DATA_WIDTH-1:0]      pkt_o
);

  always_comb begin
    pkt_o = '0;
    pkt_o[CEP_MSG_TYPE_LO     +: CEP_MSG_TYPE_WIDTH]     = hdr_i.msg_type;
    pkt_o[CEP_LENGTH_LO       +: CEP_LENGTH_WIDTH]       = hdr_i.length;
    pkt_o[CEP_MSHRID_LO       +: CEP_MSHRID_WIDTH]       = hdr_i.mshrid;
    pkt_o[CEP_MESI_LO         +: CEP_MESI_WIDTH]         = hdr_i.mesi;
    pkt_o[CEP_SUBLINE_ID_LO   +: CEP_SUBLINE_ID_WIDTH]   = hdr_i.subline_id;
    pkt_o[CEP_LAST_SUBLINE_LO +: CEP_LAST_SUBLINE_WIDTH] = hdr_i.last_subline;
    pkt_o[CEP_IS_REQ_BIT]                                = is_request_i;
    pkt_o[CEP_DATA_SIZE_LO    +: CEP_DATA_SIZE_WIDTH]    = ext_i.data_size;
    pkt_o[CEP_CACHE_TYPE_LO   +: CEP_CACHE_TYPE_WIDTH]   = ext_i.cache_type;
    pkt_o[CEP_ADDR_LO         +: CEP_ADDR_WIDTH]         = ext_i.addr;
    pkt_o[CEP_SRC_CHIPID_LO   +: CEP_SRC_CHIPID_WIDTH]   = ext_i.src_chipid;
    if (is_request_i) begin
      pkt_o[CEP_REQ_DATA_SUBWORD * CEP_WORD_WIDTH +: CEP_REQ_DATA_WIDTH] =
        data_i[CEP_REQ_DATA_WIDTH-1:0];
    end else begin
      pkt_o[CEP_RESP_DATA_SUBWORD * CEP_WORD_WIDTH +: CEP_RESP_DATA_WIDTH] = data_i;
    end
  end

endmodule

// File: rtl/cep_tx_arb.sv
// CEP transmit scheduler: response-priority arbiter with a starvation bound for
// requests, one shared encoder and a single registered output stage.
module cep_tx_arb
  import cep_tx_arb_pkg::*;
#(
  parameter int unsigned MAX_RESP_BURST = 4
) (
  input  logic                              clk,
  input  logic                              rst,

  input  logic                              req_valid,
  output logic                              req_ready,
  input  logic [CEP_LAST_SUBLINE_WIDTH-1:0] req_last_subline,
  input  logic [CEP_SUBLINE_ID_WIDTH-1:0]   req_subline_id,
  input  logic [CEP_MESI_WIDTH-1:0]         req_mesi,
  input  logic [CEP_MSHRID_WIDTH-1:0]       req_mshrid,
  input  logic [CEP_MSG_TYPE_WIDTH-1:0]     req_msg_type,
  input  logic [CEP_LENGTH_WIDTH-1:0]       req_length,
  input  logic [CEP_DATA_SIZE_WIDTH-1:0]    req_data_size,
  input  logic [CEP_CACHE_TYPE_WIDTH-1:0]   req_cache_type,
  input  logic [CEP_ADDR_WIDTH-1:0]         req_addr,
  input  logic [CEP_SRC_CHIPID_WIDTH-1:0]   req_src_chipid,
  input  logic [CEP_REQ_DATA_WIDTH-1:0]     req_data,

  input  logic                              resp_valid,
  output logic                              resp_ready,
  input  logic [CEP_LAST_SUBLINE_WIDTH-1:0] resp_last_subline,
  input  logic [CEP_SUBLINE_ID_WIDTH-1:0]   resp_subline_id,
  input  logic [CEP_MESI_WIDTH-1:0]         resp_mesi,
  input  logic [CEP_MSHRID_WIDTH-1:0]       resp_mshrid,
  input  logic [CEP_MSG_TYPE_WIDTH-1:0]     resp_msg_type,
  input  logic [CEP_LENGTH_WIDTH-1:0]       resp_length,
  input  logic [CEP_RESP_DATA_WIDTH-1:0]    resp_data,

  output logic                              cep_valid,
  input  logic                              cep_ready,
  output logic [CEP_DATA_WIDTH-1:0]         cep_pkg
);

  localparam starve_cnt_t MaxBurst = starve_cnt_t'(MAX_RESP_BURST);

  logic                          cep_valid_q, cep_valid_d;
  logic [CEP_DATA_WIDTH-1:0]     cep_pkg_q, cep_pkg_d;
  starve_cnt_t                   starve_cnt_q, starve_cnt_d;

  logic                          can_load;
  logic                          starve_hit;
  logic                          grant_req;
  logic                          grant_resp;
  logic                          accept;

  cep_hdr_t                      req_hdr;
  cep_hdr_t                      resp_hdr;
  cep_hdr_t                      enc_hdr;
  cep_req_ext_t                  enc_ext;
  logic [CEP_RESP_DATA_WIDTH-1:0] enc_data;
  logic [CEP_DATA_WIDTH-1:0]     enc_pkt;

  // Arbitration: grant depends only on valids and the starvation count.
  assign can_load   = !cep_valid_q || cep_ready;
  assign starve_hit = (starve_cnt_q == MaxBurst);
  assign grant_req  = req_valid && (!resp_valid || starve_hit);
  assign grant_resp = resp_valid && !grant_req;
  assign req_ready  = grant_req  && can_load && !rst;
  assign resp_ready = grant_resp && can_load && !rst;
  assign accept     = req_ready || resp_ready;

  assign req_hdr = '{
    last_subline: req_last_subline,
    subline_id:   req_subline_id,
    mesi:         req_mesi,
    mshrid:       req_mshrid,
    msg_type:     req_msg_type,
    length:       req_length
  };

  assign resp_hdr = '{
    last_subline: resp_last_subline,
    subline_id:   resp_subline_id,
    mesi:         resp_mesi,
    mshrid:       resp_mshrid,
    msg_type:     resp_msg_type,
    length:       resp_length
  };

  always_comb begin
    enc_hdr  = resp_hdr;
    enc_ext  = '0;
    enc_data = resp_data;
    if (grant_req) begin
      enc_hdr  = req_hdr;
      enc_ext  = '{
        data_size:  req_data_size,
        cache_type: req_cache_type,
        addr:       req_addr,
        src_chipid: req_src_chipid
      };
      enc_data = cep_pad_req_data(req_data);
    end
  end

  cep_tx_arb_encoder u_encoder (
    .is_request_i (grant_req),
    .hdr_i        (enc_hdr),
    .ext_i        (enc_ext),
    .data_i       (enc_data),
    .pkt_o        (enc_pkt)
  );

  always_comb begin
    cep_valid_d = cep_valid_q;
    cep_pkg_d   = cep_pkg_q;
    if (accept) begin
      cep_valid_d = 1'b1;
      cep_pkg_d   = enc_pkt;
    end else if (cep_ready) begin
      // Drained with nothing behind it; payload is left as-is.
      cep_valid_d = 1'b0;
    end
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (resp_ready) begin
      if (!req_valid) begin
        starve_cnt_d = '0;
      end else if (starve_cnt_q < MaxBurst) begin
        starve_cnt_d = starve_cnt_q + 1'b1;
      end else begin
        starve_cnt_d = MaxBurst;
      end
    end else if (req_ready) begin
      starve_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cep_valid_q  <= 1'b0;
      cep_pkg_q    <= '0;
      starve_cnt_q <= '0;
    end else begin
      cep_valid_q  <= cep_valid_d;
      cep_pkg_q    <= cep_pkg_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign cep_valid = cep_valid_q;
  assign cep_pkg   = cep_pkg_q;

endmodule

// File: tb/tb_cep_tx_arb.sv
// Bench for cep_tx_arb: directed scenarios with literal expectations, then
// random traffic checked every cycle against a packet-level reference model.
module tb_cep_tx_arb;
  import cep_tx_arb_pkg::*;

  localparam int MAXB = 4;

  logic clk = 1'b0;
  logic rst;
  logic req_valid, resp_valid, cep_ready;
  cep_hdr_t req_h, resp_h;
  cep_req_ext_t req_x;
  logic [CEP_REQ_DATA_WIDTH-1:0]  req_data;
  logic [CEP_RESP_DATA_WIDTH-1:0] resp_data;

  logic req_ready, resp_ready, cep_valid;
  logic [CEP_DATA_WIDTH-1:0] cep_pkg;
  logic req_ready0, resp_ready0, cep_valid0;
  logic [CEP_DATA_WIDTH-1:0] cep_pkg0;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model state
  bit m_valid = 0;
  logic [CEP_DATA_WIDTH-1:0] m_pkg = '0;
  int m_cnt = 0;
  bit m_req_acc = 0, m_resp_acc = 0, m_rst_prev = 0;

  always #5 clk = ~clk;

  cep_tx_arb #(.MAX_RESP_BURST(MAXB)) dut (
    .clk (clk), .rst (rst),
    .req_valid (req_valid), .req_ready (req_ready),
    .req_last_subline (req_h.last_subline), .req_subline_id (req_h.subline_id),
    .req_mesi (req_h.mesi), .req_mshrid (req_h.mshrid), .req_msg_type (req_h.msg_type),
    .req_length (req_h.length), .req_data_size (req_x.data_size),
    .req_cache_type (req_x.cache_type), .req_addr (req_x.addr),
    .req_src_chipid (req_x.src_chipid), .req_data (req_data),
    .resp_valid (resp_valid), .resp_ready (resp_ready),
    .resp_last_subline (resp_h.last_subline), .resp_subline_id (resp_h.subline_id),
    .resp_mesi (resp_h.mesi), .resp_mshrid (resp_h.mshrid),
    .resp_msg_type (resp_h.msg_type), .resp_length (resp_h.length),
    .resp_data (resp_data),
    .cep_valid (cep_valid), .cep_ready (cep_ready), .cep_pkg (cep_pkg)
  );

  cep_tx_arb #(.MAX_RESP_BURST(0)) dut0 (
    .clk (clk), .rst (rst),
    .req_valid (req_valid), .req_ready (req_ready0),
    .req_last_subline (req_h.last_subline), .req_subline_id (req_h.subline_id),
    .req_mesi (req_h.mesi), .req_mshrid (req_h.mshrid), .req_msg_type (req_h.msg_type),
    .req_length (req_h.length), .req_data_size (req_x.data_size),
    .req_cache_type (req_x.cache_type), .req_addr (req_x.addr),
    .req_src_chipid (req_x.src_chipid), .req_data (req_data),
    .resp_valid (resp_valid), .resp_ready (resp_ready0),
    .resp_last_subline (resp_h.last_subline), .resp_subline_id (resp_h.subline_id),
    .resp_mesi (resp_h.mesi), .resp_mshrid (resp_h.mshrid),
    .resp_msg_type (resp_h.msg_type), .resp_length (resp_h.length),
    .resp_data (resp_data),
    .cep_valid (cep_valid0), .cep_ready (cep_ready), .cep_pkg (cep_pkg0)
  );

  task automatic chk(input string name, input logic [CEP_DATA_WIDTH-1:0] got,
                     input logic [CEP_DATA_WIDTH-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h, want %0h", name, $time, got, exp);
    end
  endtask

  task automatic chk_seq(input string name, input string got, input string exp);
    n_cmp++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %s, want %s", name, $time, got, exp);
    end
  endtask

  // Packet built as an array of 64-bit words from the documented layout.
  function automatic logic [CEP_DATA_WIDTH-1:0] exp_pkt(
    input bit is_req, input cep_hdr_t h, input cep_req_ext_t x_in,
    input logic [CEP_RESP_DATA_WIDTH-1:0] d
  );
    logic [63:0] w [8];
    logic [CEP_DATA_WIDTH-1:0] p;
    cep_req_ext_t x;
    x = is_req ? x_in : '0;
    for (int k = 0; k < 8; k++) w[k] = '0;
    w[0] = {30'd0, x.cache_type, x.data_size, is_req, h.last_subline, h.subline_id,
            h.mesi, h.mshrid, h.length, h.msg_type};
    if (is_req) begin
      w[1] = {10'd0, x.src_chipid, x.addr};
      for (int k = 0; k < 5; k++) w[3 + k] = d[k*64 +: 64];
    end else begin
      for (int k = 0; k < 7; k++) w[1 + k] = d[k*64 +: 64];
    end
    for (int k = 0; k < 8; k++) p[k*64 +: 64] = w[k];
    return p;
  endfunction

  task automatic rand_req();
    logic [63:0] r;
    r = {$urandom, $urandom}; req_h = r[$bits(cep_hdr_t)-1:0];
    r = {$urandom, $urandom}; req_x = r[$bits(cep_req_ext_t)-1:0];
    for (int k = 0; k < 5; k++) req_data[k*64 +: 64] = {$urandom, $urandom};
  endtask

  task automatic rand_resp();
    logic [63:0] r;
    r = {$urandom, $urandom}; resp_h = r[$bits(cep_hdr_t)-1:0];
    for (int k = 0; k < 7; k++) resp_data[k*64 +: 64] = {$urandom, $urandom};
  endtask

  // Per-cycle compare against the model; model advances at the clock edge.
  always begin : compare
    bit er, es, nv, rst_s;
    int nc;
    logic [CEP_DATA_WIDTH-1:0] np;
    @(negedge clk);
    rst_s = rst;
    er = 0; es = 0;
    if (!rst && (!m_valid || cep_ready)) begin
      if (req_valid && resp_valid) begin
        if (m_cnt >= MAXB) er = 1; else es = 1;
      end else if (req_valid) er = 1;
      else if (resp_valid) es = 1;
    end
    chk("req_ready", req_ready, er);
    chk("resp_ready", resp_ready, es);
    chk("cep_valid", cep_valid, m_valid);
    chk("cep_pkg", cep_pkg, m_pkg);
    if (m_rst_prev) chk("max0_reset", {cep_valid0, cep_pkg0}, '0);
    if (!rst && req_valid && resp_valid && (!cep_valid0 || cep_ready))
      chk("max0_tie", {req_ready0, resp_ready0}, 2'b10);
    m_req_acc = er; m_resp_acc = es;
    nv = m_valid; np = m_pkg; nc = m_cnt;
    if (rst) begin
      nv = 0; np = '0; nc = 0;
    end else if (er) begin
      nv = 1; np = exp_pkt(1, req_h, req_x, {128'd0, req_data}); nc = 0;
    end else if (es) begin
      nv = 1; np = exp_pkt(0, resp_h, req_x, resp_data);
      nc = req_valid ? ((m_cnt + 1 > MAXB) ? MAXB : m_cnt + 1) : 0;
    end else if (cep_ready) begin
      nv = 0;
    end
    @(posedge clk);
    m_valid = nv; m_pkg = np; m_cnt = nc; m_rst_prev = rst_s;
  end

  initial begin : stim
    string seq;
    logic [CEP_DATA_WIDTH-1:0] held;
    rst = 1; req_valid = 1; resp_valid = 1; cep_ready = 1;
    rand_req(); rand_resp();
    repeat (3) @(posedge clk);
    #2;
    chk("rst_readies", {req_ready, resp_ready}, 2'b00);
    chk("rst_valid", cep_valid, 1'b0);
    chk("rst_pkg", cep_pkg, '0);

    // Release with both sources waiting: R,R,R,R,Q repeating.
    @(posedge clk); #1; rst = 0;
    seq = "";
    for (int i = 0; i < 10; i++) begin
      #1;
      seq = {seq, req_ready ? "Q" : (resp_ready ? "R" : "-")};
      if (i == 1) chk("valid_after_first", cep_valid, 1'b1);
      @(posedge clk); #1;
    end
    chk_seq("tie_seq", seq, "RRRRQRRRRQ");

    // Response stream, payload word 0 = index.
    req_valid = 0;
    for (int k = 0; k <= 8; k++) begin
      if (k < 8) begin
        resp_valid = 1; resp_data[63:0] = 64'(k);
      end else resp_valid = 0;
      #1;
      if (k > 0) begin
        chk("resp_stream_valid", cep_valid, 1'b1);
        chk("resp_stream_isreq", cep_pkg[29], 1'b0);
        chk("resp_stream_word", cep_pkg[127:64], 64'(k - 1));
      end
      if (k < 8) chk("resp_stream_ready", resp_ready, 1'b1);
      @(posedge clk); #1;
    end

    // Single request.
    req_valid = 1; req_x.addr = 40'h1234; req_data[63:0] = 64'hAA;
    #1; chk("req_ready_single", req_ready, 1'b1);
    @(posedge clk); #1; req_valid = 0;
    #1;
    chk("req_isreq", cep_pkg[29], 1'b1);
    chk("req_addr", cep_pkg[103:64], 40'h1234);
    chk("req_sub3", cep_pkg[255:192], 64'hAA);
    chk("req_sub2", cep_pkg[191:128], 64'h0);

    // Backpressure for three cycles with a response waiting.
    held = exp_pkt(1, req_h, req_x, {128'd0, req_data});
    cep_ready = 0; resp_valid = 1; resp_data[63:0] = 64'h55;
    #1; chk("bp_readies", {req_ready, resp_ready}, 2'b00);
    for (int j = 1; j < 3; j++) begin
      @(posedge clk); #2;
      chk("bp_readies", {req_ready, resp_ready}, 2'b00);
      chk("bp_valid", cep_valid, 1'b1);
      chk("bp_pkg", cep_pkg, held);
    end
    cep_ready = 1;
    #1; chk("bp_release_ready", resp_ready, 1'b1);
    @(posedge clk); #1; resp_valid = 0;
    #1;
    chk("bp_next_word", cep_pkg[127:64], 64'h55);
    chk("bp_next_valid", cep_valid, 1'b1);

    // Three response wins with a request waiting, then reset mid-flight.
    @(posedge clk); #1;
    req_valid = 1; resp_valid = 1;
    for (int j = 0; j < 3; j++) begin
      #1; chk("pre_rst_resp", resp_ready, 1'b1);
      @(posedge clk); #1;
    end
    rst = 1;
    #1; chk("mid_rst_readies", {req_ready, resp_ready}, 2'b00);
    @(posedge clk); #1; rst = 0;
    #1;
    chk("mid_rst_valid", cep_valid, 1'b0);
    chk("mid_rst_pkg", cep_pkg, '0);
    seq = "";
    for (int i = 0; i < 5; i++) begin
      seq = {seq, req_ready ? "Q" : (resp_ready ? "R" : "-")};
      @(posedge clk); #2;
    end
    chk_seq("post_rst_seq", seq, "RRRRQ");

    // Random traffic, occasional resets, random backpressure.
    @(posedge clk); #1;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 199) == 0) begin
        rst = 1; req_valid = 0; resp_valid = 0;
      end else begin
        rst = 0;
        if (m_req_acc || !req_valid) begin
          req_valid = ($urandom_range(0, 2) != 0);
          if (req_valid) rand_req();
        end
        if (m_resp_acc || !resp_valid) begin
          resp_valid = ($urandom_range(0, 2) != 0);
          if (resp_valid) rand_resp();
        end
      end
      cep_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    req_valid = 0; resp_valid = 0; cep_ready = 1; rst = 0;
    repeat (3) @(posedge clk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
